nonce_sweep: RTL and testbench
==============================

NONCE_SWEEP -- requirements
Module: nonce_sweep

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles waited for hash_valid per issued header.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse, begins sweep; ignored while busy.
REQ-005 SHALL have port abort  input  1  terminates sweep.
REQ-006 SHALL have port header_in  input  640  base block header; sampled on accepted start.
REQ-007 SHALL have port nonce_start  input  32  first nonce; sampled on accepted start.
REQ-008 SHALL have port nonce_end  input  32  last nonce, inclusive; sampled on accepted start.
REQ-009 SHALL have port target  input  256  difficulty target, unsigned; sampled on accepted start.
REQ-010 SHALL have port hdr_out  output  640  header with current nonce, to message-prepare/hash stage.
REQ-011 SHALL have port hdr_valid  output  1  hdr_out valid.
REQ-012 SHALL have port hdr_ready  input  1  hash stage accepts hdr_out.
REQ-013 SHALL have port hash_in  input  256  double-SHA256 result from hash stage.
REQ-014 SHALL have port hash_valid  input  1  hash_in valid, one-cycle pulse.
REQ-015 SHALL have ports busy, done, found, timeout_err  output  1 each  status flags.
REQ-016 SHALL have ports found_nonce, hash_count  output  32 each  winning nonce; completed-hash count.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, CHECK; busy=1 in every state except IDLE.
REQ-018 IDLE: accepted start -> ISSUE next cycle; if nonce_end < nonce_start -> stay IDLE, pulse done with found=0.
REQ-019 hdr_out SHALL equal stored header with bits [31:0] replaced by current nonce byte-swapped (header[31:24]=nonce[7:0] ... header[7:0]=nonce[31:24]).
REQ-020 ISSUE: hdr_valid=1 with hdr_out stable until hdr_valid&&hdr_ready; then -> WAIT; hdr_valid=0 in all other states.
REQ-021 At most one header outstanding; hash_valid outside WAIT SHALL be ignored.
REQ-022 WAIT: hash_valid -> capture hash_in, -> CHECK; wait counter reaching TIMEOUT_CYCLES -> IDLE, pulse done, timeout_err=1, found=0.
REQ-023 CHECK (one cycle): byte-reverse captured hash to 256-bit value V; V <= target -> found=1, found_nonce=current nonce, pulse done, -> IDLE.
REQ-024 CHECK miss: nonce == nonce_end -> pulse done with found=0, -> IDLE; else nonce += 1, -> ISSUE.
REQ-025 Nonce SHALL NOT wrap: nonce_end=0xFFFFFFFF terminates after checking 0xFFFFFFFF.
REQ-026 Latency: start at cycle 0 -> hdr_valid at cycle 1; hash_valid at cycle N -> done at N+2 (hit) or hdr_valid at N+2 (miss).
REQ-027 done SHALL be a one-cycle pulse; found, found_nonce, timeout_err SHALL hold until next accepted start, which clears them.
REQ-028 abort in any non-IDLE state -> IDLE next cycle, pulse done, found=0; abort in IDLE ignored.
REQ-029 abort coincident with hash_valid or hdr_ready SHALL win; hash discarded.

Reset
REQ-030 rst low SHALL immediately force IDLE, and hdr_valid, busy, done, found, timeout_err, found_nonce, hash_count, hdr_out, wait counter to 0.
REQ-031 Reset mid-sweep SHALL discard all state; no done pulse on release.

Configuration
REQ-032 Macro NONCE_SWEEP_STATS_EN defined: hash_count increments on each hash_valid accepted in WAIT, clears on accepted start, saturates at 0xFFFFFFFF.
REQ-033 Macro NONCE_SWEEP_STATS_EN undefined: counter logic omitted, hash_count tied to 0; all else identical.

Verification
REQ-034 Header from block 0x...4d4c86041b, nonce 0..3, stub hash returns V > target for 0,1,2, V = target for 3 -> done at nonce 3, found=1, found_nonce=3, hash_count=4 (stats on).
REQ-035 nonce_start=5, nonce_end=4 -> done pulse 1 cycle after start, found=0, hdr_valid never high.
REQ-036 nonce_start=0xFFFFFFFE, nonce_end=0xFFFFFFFF, all misses -> exactly 2 headers issued, done, found=0, no wrap.
REQ-037 hdr_ready low 5 cycles -> hdr_valid high and hdr_out stable throughout; stub never answers, TIMEOUT_CYCLES=16 -> timeout_err=1, done 16 cycles after handshake.
REQ-038 abort same cycle as hash_valid with V=0 -> found=0, done pulse, IDLE; rst low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/nonce_sweep.sv
// Nonce sweep controller: issues one header per nonce to the hash stage and checks each hash against target.
// Optional hash counter enabled by defining NONCE_SWEEP_STATS_EN.
module nonce_sweep #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic [639:0] hdr_out,
    output logic         hdr_valid,
    input  logic         hdr_ready,
    input  logic [255:0] hash_in,
    input  logic         hash_valid,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         timeout_err,
    output logic [31:0]  found_nonce,
    output logic [31:0]  hash_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [607:0]  r_header_hi;
    logic [31:0]   r_nonce;
    logic [31:0]   r_nonce_end;
    logic [255:0]  r_target;
    logic [255:0]  r_hash;
    logic [31:0]   r_wait_cnt;
    logic          r_done;
    logic          r_found;
    logic          r_timeout_err;
    logic [31:0]   r_found_nonce;
    logic          w_accept;
    logic          w_empty;
    logic          w_handshake;
    logic          w_hash_acc;
    logic          w_timeout;
    logic          w_hit;
    logic          w_last;
    logic          w_done_nxt;
    logic          w_unused_hdr_lo;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Hash stage delivers the digest little-endian; the target compare is on the big-endian value.
    function automatic logic [255:0] byte_rev256(input logic [255:0] x);
        logic [255:0] y;
        for (int i = 0; i < 32; i++) begin
            y[8*i +: 8] = x[255-8*i -: 8];
        end
        return y;
    endfunction

    assign w_unused_hdr_lo = ^header_in[31:0];

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_empty     = nonce_end < nonce_start;
    assign w_handshake = (r_state == S_ISSUE) && hdr_ready && !abort;
    assign w_hash_acc  = (r_state == S_WAIT) && hash_valid && !abort;
    // Counter holds cycles elapsed since the handshake, so done lands TIMEOUT_CYCLES after it.
    assign w_timeout   = (r_state == S_WAIT) && !hash_valid && !abort &&
                         ((r_wait_cnt + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign w_hit       = byte_rev256(r_hash) <= r_target;
    assign w_last      = r_nonce == r_nonce_end;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_empty) w_done_nxt = 1'b1;
                    else         w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (hdr_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort || w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (hash_valid) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || w_hit || w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_header_hi   <= '0;
            r_nonce       <= '0;
            r_nonce_end   <= '0;
            r_target      <= '0;
            r_hash        <= '0;
            r_wait_cnt    <= '0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_found_nonce <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_accept) begin
                r_header_hi   <= header_in[639:32];
                r_nonce       <= nonce_start;
                r_nonce_end   <= nonce_end;
                r_target      <= target;
                r_found       <= 1'b0;
                r_found_nonce <= '0;
                r_timeout_err <= 1'b0;
            end
            if (w_handshake)            r_wait_cnt <= 32'd1;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 32'd1;
            if (w_hash_acc) r_hash <= hash_in;
            if (w_timeout)  r_timeout_err <= 1'b1;
            // Nonce never steps past nonce_end, so an end of 0xFFFFFFFF cannot wrap.
            if ((r_state == S_CHECK) && !abort) begin
                if (w_hit) begin
                    r_found       <= 1'b1;
                    r_found_nonce <= r_nonce;
                end else if (!w_last) begin
                    r_nonce <= r_nonce + 32'd1;
                end
            end
        end
    end

`ifdef NONCE_SWEEP_STATS_EN
    logic [31:0] r_hash_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hash_count <= '0;
        end else if (w_accept) begin
            r_hash_count <= '0;
        end else if (w_hash_acc && (r_hash_count != 32'hFFFF_FFFF)) begin
            r_hash_count <= r_hash_count + 32'd1;
        end
    end

    assign hash_count = r_hash_count;
`else
    assign hash_count = '0;
`endif

    assign hdr_out     = {r_header_hi, bswap32(r_nonce)};
    assign hdr_valid   = (r_state == S_ISSUE);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign found       = r_found;
    assign timeout_err = r_timeout_err;
    assign found_nonce = r_found_nonce;

endmodule

// File: tb/tb_nonce_sweep.sv
// Directed bench for nonce_sweep: find, empty range, no-wrap, stall/timeout, abort and reset scenarios.
module tb_nonce_sweep;
    localparam int TO = 16;
`ifdef NONCE_SWEEP_STATS_EN
    localparam logic [31:0] EXP_CNT_FIND = 32'd4;
`else
    localparam logic [31:0] EXP_CNT_FIND = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [639:0] header_in;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [255:0] target;
    logic [639:0] hdr_out;
    logic         hdr_valid;
    logic         hdr_ready;
    logic [255:0] hash_in;
    logic         hash_valid;
    logic         busy;
    logic         done;
    logic         found;
    logic         timeout_err;
    logic [31:0]  found_nonce;
    logic [31:0]  hash_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [639:0] hdr_base;
    logic [255:0] tgt;
    logic [255:0] hash_hit;
    logic [255:0] hash_miss;

    nonce_sweep #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .header_in(header_in), .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .hdr_out(hdr_out), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hash_in(hash_in), .hash_valid(hash_valid),
        .busy(busy), .done(done), .found(found), .timeout_err(timeout_err),
        .found_nonce(found_nonce), .hash_count(hash_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] ns, input logic [31:0] ne);
        header_in   = hdr_base;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tgt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; hdr_ready = 1'b0; hash_valid = 1'b0;
        hash_in = '0; header_in = '0; nonce_start = '0; nonce_end = '0; target = '0;
        #2 rst = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy, done, hdr_valid, found, timeout_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 00000", {busy, done, hdr_valid, found, timeout_err});
        end
        n_checks++;
        if (found_nonce !== 32'd0) begin n_fail++; $display("FAIL reset_found_nonce got %h exp 0", found_nonce); end
        n_checks++;
        if (hash_count !== 32'd0) begin n_fail++; $display("FAIL reset_hash_count got %h exp 0", hash_count); end
        n_checks++;
        if (hdr_out !== 640'd0) begin n_fail++; $display("FAIL reset_hdr_out got %h exp 0", hdr_out[31:0]); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_find;
        logic [639:0] exp_hdr;
        do_start(32'd0, 32'd3);
        for (int n = 0; n < 4; n++) begin
            exp_hdr = {hdr_base[639:32], 8'(n), 24'h0};
            n_checks++;
            if ({hdr_valid, busy, done} !== 3'b110) begin
                n_fail++; $display("FAIL find_issue%0d flags got %b exp 110", n, {hdr_valid, busy, done});
            end
            n_checks++;
            if (hdr_out !== exp_hdr) begin
                n_fail++; $display("FAIL find_hdr%0d got %h exp %h", n, hdr_out[63:0], exp_hdr[63:0]);
            end
            hdr_ready = 1'b1; tick(); hdr_ready = 1'b0;
            n_checks++;
            if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL find_wait%0d hdr_valid got %b exp 0", n, hdr_valid); end
            hash_valid = 1'b1;
            hash_in = (n == 3) ? hash_hit : hash_miss;
            tick();
            hash_valid = 1'b0;
            tick();
        end
        n_checks++;
        if ({done, found, busy} !== 3'b110) begin
            n_fail++; $display("FAIL find_done flags got %b exp 110", {done, found, busy});
        end
        n_checks++;
        if (found_nonce !== 32'd3) begin n_fail++; $display("FAIL find_nonce got %h exp 3", found_nonce); end
        n_checks++;
        if (hash_count !== EXP_CNT_FIND) begin
            n_fail++; $display("FAIL find_hash_count got %0d exp %0d", hash_count, EXP_CNT_FIND);
        end
        tick();
        n_checks++;
        if ({done, found} !== 2'b01) begin n_fail++; $display("FAIL find_hold got %b exp 01", {done, found}); end
    endtask

    task automatic test_empty_range;
        logic seen_hv;
        do_start(32'd5, 32'd4);
        n_checks++;
        if ({done, found, busy, hdr_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL empty_done flags got %b exp 1000", {done, found, busy, hdr_valid});
        end
        seen_hv = 1'b0;
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL empty_pulse done got %b exp 0", done); end
        for (int c = 0; c < 4; c++) begin
            if (hdr_valid !== 1'b0) seen_hv = 1'b1;
            tick();
        end
        n_checks++;
        if (seen_hv !== 1'b0) begin n_fail++; $display("FAIL empty_no_hdr hdr_valid seen %b exp 0", seen_hv); end
    endtask

    task automatic test_no_wrap;
        logic [31:0] lows [2];
        int cnt;
        logic seen_hv;
        lows[0] = '0; lows[1] = '0;
        cnt = 0;
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        hdr_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (hdr_valid) begin
                if (cnt < 2) lows[cnt] = hdr_out[31:0];
                cnt++;
                tick();
                hash_valid = 1'b1; hash_in = hash_miss;
                tick();
                hash_valid = 1'b0;
            end else begin
                tick();
            end
        end
        hdr_ready = 1'b0;
        n_checks++;
        if (cnt !== 2) begin n_fail++; $display("FAIL nowrap_count got %0d exp 2", cnt); end
        n_checks++;
        if (lows[0] !== 32'hFEFF_FFFF) begin n_fail++; $display("FAIL nowrap_hdr0 got %h exp feffffff", lows[0]); end
        n_checks++;
        if (lows[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nowrap_hdr1 got %h exp ffffffff", lows[1]); end
        n_checks++;
        if ({done, found, busy} !== 3'b100) begin
            n_fail++; $display("FAIL nowrap_done flags got %b exp 100", {done, found, busy});
        end
        seen_hv = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (hdr_valid !== 1'b0) seen_hv = 1'b1;
        end
        n_checks++;
        if (seen_hv !== 1'b0) begin n_fail++; $display("FAIL nowrap_reissue hdr_valid seen %b exp 0", seen_hv); end
    endtask

    task automatic test_stall_timeout;
        logic [639:0] exp_hdr;
        logic stable;
        int cyc;
        exp_hdr = {hdr_base[639:32], 32'h0700_0000};
        do_start(32'd7, 32'd9);
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (hdr_valid !== 1'b1 || hdr_out !== exp_hdr) stable = 1'b0;
            hash_valid = (c == 2);
            hash_in = hash_hit;
            tick();
        end
        hash_valid = 1'b0;
        n_checks++;
        if ({stable, hdr_valid} !== 2'b11) begin
            n_fail++; $display("FAIL stall_stable got %b exp 11", {stable, hdr_valid});
        end
        hdr_ready = 1'b1; tick(); hdr_ready = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== TO) begin n_fail++; $display("FAIL timeout_latency got %0d exp %0d", cyc, TO); end
        n_checks++;
        if ({timeout_err, found, busy} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_flags got %b exp 100", {timeout_err, found, busy});
        end
        n_checks++;
        if (hash_count !== 32'd0) begin n_fail++; $display("FAIL timeout_hash_count got %0d exp 0", hash_count); end
        tick();
        n_checks++;
        if ({done, timeout_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_hold got %b exp 01", {done, timeout_err}); end
    endtask

    task automatic test_abort;
        abort = 1'b1; tick(); abort = 1'b0;
        n_checks++;
        if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL abort_idle got %b exp 00", {done, busy}); end
        do_start(32'd0, 32'd10);
        hdr_ready = 1'b1; tick(); hdr_ready = 1'b0;
        hash_valid = 1'b1; hash_in = '0; abort = 1'b1;
        tick();
        hash_valid = 1'b0; abort = 1'b0;
        n_checks++;
        if ({done, found, busy, timeout_err} !== 4'b1000) begin
            n_fail++; $display("FAIL abort_done flags got %b exp 1000", {done, found, busy, timeout_err});
        end
        n_checks++;
        if (hash_count !== 32'd0) begin n_fail++; $display("FAIL abort_hash_count got %0d exp 0", hash_count); end
        tick();
        n_checks++;
        if ({done, hdr_valid, busy, found} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_after got %b exp 0000", {done, hdr_valid, busy, found});
        end
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        do_start(32'd0, 32'd10);
        hdr_ready = 1'b1; tick(); hdr_ready = 1'b0;
        hash_valid = 1'b1; hash_in = hash_miss; tick(); hash_valid = 1'b0;
        tick();
        hdr_ready = 1'b1; tick(); hdr_ready = 1'b0;
        n_checks++;
        if ({busy, hdr_valid} !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre got %b exp 10", {busy, hdr_valid}); end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, found, timeout_err, hdr_valid} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_flags got %b exp 00000", {busy, done, found, timeout_err, hdr_valid});
        end
        n_checks++;
        if (hdr_out !== 640'd0) begin n_fail++; $display("FAIL rstmid_hdr_out got %h exp 0", hdr_out[63:0]); end
        n_checks++;
        if ({found_nonce, hash_count} !== 64'd0) begin
            n_fail++; $display("FAIL rstmid_counts got %h exp 0", {found_nonce, hash_count});
        end
        #3 rst = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_release done/busy seen %b exp 0", seen_done); end
    endtask

    initial begin
        hdr_base  = {16{40'h4d4c86041b}};
        tgt       = {32'h0, {224{1'b1}}};
        hash_hit  = {{224{1'b1}}, 32'h0};
        hash_miss = 256'h0100_0000;
        test_reset();
        test_find();
        test_empty_range();
        test_no_wrap();
        test_stall_timeout();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
